// File: rtl/scan_resp_board_store_if.sv
// Scanner <-> board-store bus: place, read, weight-write, search control/result.
// Latency: n/a (signal bundle only).
// Backpressure: none on the bus itself; busy tells the scanner when writes would be dropped.
//
// Signals: plcEna/plcX/plcY/plcColour  place-stone strobe and target cell
//          enaRead/XlocV/YlocV         combinational board read (address shared with weight writes)
//          boardDataOut                cell contents (0 black, 1 white, 2 empty, 3 no read)
//          enaWRITE/weight             weight-write strobe and value
//          clrScores/findStart         start clear / start best-move search
//          busy/doneFind/bestValid/bestX/bestY/bestScore/wrDropErr  status and result
// master = scanner/engine side, slave = board store.
interface scan_resp_board_store_if #(
  parameter int SCORE_W = 8
) ();
  logic               plcEna;
  logic [4:0]         plcX;
  logic [4:0]         plcY;
  logic               plcColour;
  logic               enaRead;
  logic [4:0]         XlocV;
  logic [4:0]         YlocV;
  logic [1:0]         boardDataOut;
  logic               enaWRITE;
  logic [3:0]         weight;
  logic               clrScores;
  logic               findStart;
  logic               busy;
  logic               doneFind;
  logic               bestValid;
  logic [4:0]         bestX;
  logic [4:0]         bestY;
  logic [SCORE_W-1:0] bestScore;
  logic               wrDropErr;

  modport master (
    output plcEna, plcX, plcY, plcColour,
    output enaRead, XlocV, YlocV,
    input  boardDataOut,
    output enaWRITE, weight, clrScores, findStart,
    input  busy, doneFind, bestValid, bestX, bestY, bestScore, wrDropErr
  );

  modport slave (
    input  plcEna, plcX, plcY, plcColour,
    input  enaRead, XlocV, YlocV,
    output boardDataOut,
    input  enaWRITE, weight, clrScores, findStart,
    output busy, doneFind, bestValid, bestX, bestY, bestScore, wrDropErr
  );
endinterface

// File: rtl/scan_resp_board_store.sv
// Board store + per-cell score table; sweeps the table to report the best empty cell.
// Latency: board read 0 cycles; search findStart -> doneFind 362 cycles; clear 361 busy cycles.
// Backpressure: none; weight writes arriving while busy are dropped and flagged in wrDropErr.
//
// Ports: clk, reset (async, active-high); bus (slave modport of scan_resp_board_store_if).
// Optional feature macro: THREAT_PRIORITY_EN -- when defined, a per-cell threat flag is kept
// (set by a write of weight T_WEIGHT) and the search key becomes {threat, score}; when undefined
// no threat flags exist and the key is the score alone.
module scan_resp_board_store #(
  parameter int BRD_DIM = 19,
  parameter int SCORE_W = 8
`ifdef THREAT_PRIORITY_EN
  ,
  parameter int T_WEIGHT = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  scan_resp_board_store_if.slave   bus
);

  localparam int NCELL = BRD_DIM * BRD_DIM;
  localparam int IDX_W = $clog2(NCELL);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NCELL - 1);
  localparam logic [4:0]         LAST_COL  = 5'(BRD_DIM - 1);
  localparam logic [4:0]         DIM5      = 5'(BRD_DIM);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
`ifdef THREAT_PRIORITY_EN
  localparam int KEY_W = SCORE_W + 1;
`else
  localparam int KEY_W = SCORE_W;
`endif

  localparam logic [1:0] CELL_EMPTY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEARCH,
    ST_REPORT
  } state_t;

  function automatic logic [IDX_W-1:0] f_lin_idx(input logic [4:0] x, input logic [4:0] y);
    return IDX_W'(y) * IDX_W'(BRD_DIM) + IDX_W'(x);
  endfunction

  // Storage
  logic [1:0]         r_board [NCELL];
  logic [SCORE_W-1:0] r_score [NCELL];
`ifdef THREAT_PRIORITY_EN
  logic [NCELL-1:0]   r_threat;
`endif

  // Control / sweep state
  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [4:0]         r_col;
  logic [4:0]         r_row;
  logic               w_busy;
  logic               w_sweep_last;

  // Running best during a search
  logic               r_found;
  logic [KEY_W-1:0]   r_best_key;
  logic [4:0]         r_best_x;
  logic [4:0]         r_best_y;

  // Registered results
  logic               r_done;
  logic               r_out_valid;
  logic [4:0]         r_out_x;
  logic [4:0]         r_out_y;
  logic [SCORE_W-1:0] r_out_score;
  logic               r_drop_err;

  // Address decode
  logic               w_loc_in_rng;
  logic [IDX_W-1:0]   w_loc_idx;
  logic               w_plc_in_rng;
  logic [IDX_W-1:0]   w_plc_idx;
  logic [1:0]         w_rd_dat;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_sat;
  logic               w_wr_accept;
  logic               w_cand_empty;
  logic [KEY_W-1:0]   w_cand_key;
  logic               w_cand_take;

  // ---------------------------------------------------------------------------
  // Address decode, board read, weight accumulate
  // ---------------------------------------------------------------------------
  always_comb begin
    w_loc_in_rng = (bus.XlocV < DIM5) && (bus.YlocV < DIM5);
    // Out-of-range coordinates are steered to cell 0 so the array index stays legal;
    // the in-range flag masks every use of that cell.
    w_loc_idx    = w_loc_in_rng ? f_lin_idx(bus.XlocV, bus.YlocV) : '0;
    w_plc_in_rng = (bus.plcX < DIM5) && (bus.plcY < DIM5);
    w_plc_idx    = w_plc_in_rng ? f_lin_idx(bus.plcX, bus.plcY) : '0;

    if (!bus.enaRead) begin
      w_rd_dat = 2'b11;
    end else if (!w_loc_in_rng) begin
      w_rd_dat = CELL_EMPTY;
    end else begin
      w_rd_dat = r_board[w_loc_idx];
    end

    w_sum       = {1'b0, r_score[w_loc_idx]} + (SCORE_W + 1)'(bus.weight);
    w_sat       = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];
    w_wr_accept = bus.enaWRITE && w_loc_in_rng && (r_state == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Search candidate at the current sweep index
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cand_empty = (r_board[r_idx] == CELL_EMPTY);
`ifdef THREAT_PRIORITY_EN
    w_cand_key   = {r_threat[r_idx], r_score[r_idx]};
`else
    w_cand_key   = r_score[r_idx];
`endif
    // Strictly-greater compare keeps the lowest index on ties; the first empty
    // cell is always taken so a board of all-zero scores still yields a move.
    w_cand_take  = w_cand_empty && (!r_found || (w_cand_key > r_best_key));
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b1;
    w_sweep_last = (r_idx == LAST_IDX);
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.clrScores) begin
          w_state_nxt = ST_CLEAR;
        end else if (bus.findStart) begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_CLEAR: begin
        if (w_sweep_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (w_sweep_last) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep counters and running best
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_found    <= 1'b0;
      r_best_key <= '0;
      r_best_x   <= '0;
      r_best_y   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR, ST_SEARCH: begin
          // Row/column are tracked alongside the linear index to avoid a divider.
          r_idx <= r_idx + 1'b1;
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if ((r_state == ST_SEARCH) && w_cand_take) begin
            r_found    <= 1'b1;
            r_best_key <= w_cand_key;
            r_best_x   <= r_col;
            r_best_y   <= r_row;
          end
        end
        ST_IDLE: begin
          r_idx      <= '0;
          r_col      <= '0;
          r_row      <= '0;
          r_found    <= 1'b0;
          r_best_key <= '0;
          r_best_x   <= '0;
          r_best_y   <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers and sticky drop flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_score <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_REPORT);
      if (r_state == ST_REPORT) begin
        // Best registers are still zero when nothing was found.
        r_out_valid <= r_found;
        r_out_x     <= r_best_x;
        r_out_y     <= r_best_y;
        r_out_score <= r_best_key[SCORE_W-1:0];
      end
      if (bus.enaWRITE && (r_state != ST_IDLE)) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Board array: place requests accepted in every state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCELL; i++) begin
        r_board[i] <= CELL_EMPTY;
      end
    end else if (bus.plcEna && w_plc_in_rng) begin
      r_board[w_plc_idx] <= {1'b0, bus.plcColour};
    end
  end

  // ---------------------------------------------------------------------------
  // Score table (and threat flags): cleared by the sweep, accumulated in IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCELL; i++) begin
        r_score[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_score[r_idx] <= '0;
    end else if (w_wr_accept) begin
      r_score[w_loc_idx] <= w_sat;
    end
  end

`ifdef THREAT_PRIORITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_threat <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_threat[r_idx] <= 1'b0;
    end else if (w_wr_accept && (bus.weight == 4'(T_WEIGHT))) begin
      r_threat[w_loc_idx] <= 1'b1;
    end
  end
`endif

  assign bus.boardDataOut = w_rd_dat;
  assign bus.busy         = w_busy;
  assign bus.doneFind     = r_done;
  assign bus.bestValid    = r_out_valid;
  assign bus.bestX        = r_out_x;
  assign bus.bestY        = r_out_y;
  assign bus.bestScore    = r_out_score;
  assign bus.wrDropErr    = r_drop_err;

endmodule
